// File: rtl/qam16_map.sv
// 16-QAM transmit mapper: packs a serial bit stream MSB-first into 4-bit symbols
// and presents Gray-coded signed I/Q points through a registered valid/ready stage.
module qam16_map #(
  parameter int L_AMP = 485,
  parameter int S_AMP = 161,
  parameter int IDX_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  output logic                    bit_ready,
  input  logic                    bit_last,
  output logic signed [12:0]      sym_real,
  output logic signed [12:0]      sym_imag,
  output logic [3:0]              sym_bits,
  output logic                    sym_valid,
  input  logic                    sym_ready,
  output logic                    sym_last,
  output logic [IDX_W-1:0]        sym_index
);

  localparam logic signed [12:0] L_PT = 13'(L_AMP);
  localparam logic signed [12:0] S_PT = 13'(S_AMP);

  function automatic logic signed [12:0] map_real(input logic [1:0] b);
    case (b)
      2'b00:   return -L_PT;
      2'b01:   return -S_PT;
      2'b11:   return S_PT;
      default: return L_PT;
    endcase
  endfunction

  function automatic logic signed [12:0] map_imag(input logic [1:0] b);
    case (b)
      2'b00:   return L_PT;
      2'b01:   return S_PT;
      2'b11:   return -S_PT;
      default: return -L_PT;
    endcase
  endfunction

  logic [1:0]               cnt_q, cnt_d;
  logic [3:0]               sh_q, sh_d;
  logic                     sym_valid_q, sym_valid_d;
  logic                     sym_last_q, sym_last_d;
  logic [3:0]               sym_bits_q, sym_bits_d;
  logic signed [12:0]       sym_real_q, sym_real_d;
  logic signed [12:0]       sym_imag_q, sym_imag_d;
  logic [IDX_W-1:0]         sym_index_q, sym_index_d;

  logic                     accept;
  logic                     drain;
  logic                     load;
  logic [3:0]               word;

  assign bit_ready = !sym_valid_q || sym_ready;

  always_comb begin
    accept      = bit_valid && bit_ready;
    drain       = sym_valid_q && sym_ready;
    load        = accept && ((cnt_q == 2'd3) || bit_last);
    // Bits land at position 3-cnt; lower positions stay zero, which pads short symbols.
    word        = sh_q | ({3'b000, bit_in} << (2'd3 - cnt_q));
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    sym_valid_d = sym_valid_q;
    sym_last_d  = sym_last_q;
    sym_bits_d  = sym_bits_q;
    sym_real_d  = sym_real_q;
    sym_imag_d  = sym_imag_q;
    sym_index_d = sym_index_q;

    // The index register always names the next symbol to present, so a symbol
    // loaded in the same cycle as a drain picks up the post-drain value.
    if (drain) begin
      sym_valid_d = 1'b0;
      sym_index_d = sym_last_q ? '0 : sym_index_q + IDX_W'(1);
    end

    if (accept) begin
      if (load) begin
        cnt_d       = 2'd0;
        sh_d        = 4'd0;
        sym_valid_d = 1'b1;
        sym_last_d  = bit_last;
        sym_bits_d  = word;
        sym_real_d  = map_real(word[3:2]);
        sym_imag_d  = map_imag(word[1:0]);
      end else begin
        cnt_d = cnt_q + 2'd1;
        sh_d  = word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= 2'd0;
      sh_q        <= 4'd0;
      sym_valid_q <= 1'b0;
      sym_last_q  <= 1'b0;
      sym_bits_q  <= 4'd0;
      sym_real_q  <= 13'sd0;
      sym_imag_q  <= 13'sd0;
      sym_index_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      sym_valid_q <= sym_valid_d;
      sym_last_q  <= sym_last_d;
      sym_bits_q  <= sym_bits_d;
      sym_real_q  <= sym_real_d;
      sym_imag_q  <= sym_imag_d;
      sym_index_q <= sym_index_d;
    end
  end

  assign sym_valid = sym_valid_q;
  assign sym_last  = sym_last_q;
  assign sym_bits  = sym_bits_q;
  assign sym_real  = sym_real_q;
  assign sym_imag  = sym_imag_q;
  assign sym_index = sym_index_q;

endmodule

// File: tb/tb_qam16_map.sv
// Bench for qam16_map: cycle-level reference model (bit queue + one output slot)
// compared every cycle, plus directed constellation/backpressure/reset scenarios.
module tb_qam16_map;

  localparam int IDX_W = 10;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    bit_in, bit_valid, bit_last, sym_ready;
  logic                    bit_ready, sym_valid, sym_last;
  logic signed [12:0]      sym_real, sym_imag;
  logic [3:0]              sym_bits;
  logic [IDX_W-1:0]        sym_index;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_q[$];
  int m_val, m_last, m_bits, m_real, m_imag, m_idx;

  qam16_map #(.L_AMP(485), .S_AMP(161), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_last(bit_last),
    .sym_real(sym_real), .sym_imag(sym_imag), .sym_bits(sym_bits),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_last(sym_last), .sym_index(sym_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Gray pair -> amplitude level, ordered from most negative to most positive.
  function automatic int gray_level(input int g);
    int lv[4] = '{-485, -161, 161, 485};
    int hi = (g >> 1) & 1;
    int lo = g & 1;
    return lv[hi * 2 + (hi ^ lo)];
  endfunction

  function automatic void model_step(input int r_, b, v, l, s);
    int ready, w;
    if (r_ != 0) begin
      m_q.delete();
      m_val = 0; m_last = 0; m_bits = 0; m_real = 0; m_imag = 0; m_idx = 0;
      return;
    end
    ready = (m_val == 0 || s != 0) ? 1 : 0;
    if (m_val != 0 && s != 0) begin
      m_idx = (m_last != 0) ? 0 : (m_idx + 1) % (1 << IDX_W);
      m_val = 0;
    end
    if (v != 0 && ready != 0) begin
      m_q.push_back(b);
      if (m_q.size() == 4 || l != 0) begin
        w = 0;
        foreach (m_q[i]) w += m_q[i] * (8 >> i);
        m_bits = w;
        m_real = gray_level(w / 4);
        m_imag = -gray_level(w % 4);
        m_last = (l != 0) ? 1 : 0;
        m_val  = 1;
        m_q.delete();
      end
    end
  endfunction

  // One clock: drive, compare against the model mid-cycle, then advance the model.
  task automatic cycle(input logic r_, b, v, l, s);
    rst = r_; bit_in = b; bit_valid = v; bit_last = l; sym_ready = s;
    @(negedge clk);
    check("bit_ready", int'(bit_ready), (m_val == 0 || s) ? 1 : 0);
    check("sym_valid", int'(sym_valid), m_val);
    check("sym_last",  int'(sym_last),  m_last);
    check("sym_bits",  int'(sym_bits),  m_bits);
    check("sym_real",  int'(sym_real),  m_real);
    check("sym_imag",  int'(sym_imag),  m_imag);
    check("sym_index", int'(sym_index), m_idx);
    @(posedge clk);
    model_step(int'(r_), int'(b), int'(v), int'(l), int'(s));
    #1;
  endtask

  task automatic send(input logic b, input logic l);
    cycle(1'b0, b, 1'b1, l, 1'b1);
  endtask

  initial begin
    int seen;
    logic [3:0] pat;
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; bit_last = 1'b0; sym_ready = 1'b0;
    m_val = 0; m_last = 0; m_bits = 0; m_real = 0; m_imag = 0; m_idx = 0;
    @(posedge clk); #1;
    model_step(1, 0, 0, 0, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_valid", int'(sym_valid), 0);
    check("rst_ready", int'(bit_ready), 1);
    check("rst_real",  int'(sym_real), 0);

    // All-zero symbol
    for (int i = 0; i < 4; i++) send(1'b0, 1'b0);
    check("t1_valid", int'(sym_valid), 1);
    check("t1_bits",  int'(sym_bits), 0);
    check("t1_real",  int'(sym_real), -485);
    check("t1_imag",  int'(sym_imag), 485);
    check("t1_index", int'(sym_index), 0);

    // 1111 then 1010
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0);
    check("t2a_real", int'(sym_real), 161);
    check("t2a_imag", int'(sym_imag), -161);
    pat = 4'b1010;
    for (int i = 3; i >= 0; i--) send(pat[i], 1'b0);
    check("t2b_real",  int'(sym_real), 485);
    check("t2b_imag",  int'(sym_imag), -485);
    check("t2b_index", int'(sym_index), 1);

    // Partial symbol 1,1 with last
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    check("t3_bits", int'(sym_bits), 12);
    check("t3_real", int'(sym_real), 161);
    check("t3_imag", int'(sym_imag), 485);
    check("t3_last", int'(sym_last), 1);
    for (int i = 0; i < 4; i++) send(1'b0, 1'b0);
    check("t3_next_index", int'(sym_index), 0);

    // Backpressure for 5 cycles with bits offered
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    pat = 4'b1001;
    for (int i = 3; i >= 0; i--) send(pat[i], 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      check("bp_ready", int'(bit_ready), 0);
      check("bp_bits",  int'(sym_bits), 9);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_drained", int'(sym_valid), 0);

    // Continuous 32-bit stream
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    seen = 0;
    for (int i = 0; i < 32; i++) begin
      send(1'($urandom_range(0, 1)), 1'b0);
      if (sym_valid) seen++;
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("stream_count", seen, 8);
    check("stream_idx_end", int'(sym_index), 8);

    // Reset with a partial symbol, then with a stalled symbol
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst1_valid", int'(sym_valid), 0);
    check("rst1_index", int'(sym_index), 0);
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst2_valid", int'(sym_valid), 0);
    check("rst2_index", int'(sym_index), 0);
    pat = 4'b0101;
    for (int i = 3; i >= 0; i--) send(pat[i], 1'b0);
    check("rst_bits", int'(sym_bits), 5);
    check("rst_real", int'(sym_real), -161);
    check("rst_imag", int'(sym_imag), 161);

    // Randomised traffic against the model
    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom_range(0, 199) == 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qam16_map.md
Name: qam16_map

Overview:
- Transmit-side 16-QAM mapper.
- Accepts a serial bit stream with a valid/ready handshake and packs it into 4-bit symbols, MSB first.
- Emits signed 13-bit I/Q constellation points through a registered valid/ready output stage, plus frame-last and symbol-index tags.
- Sits between the scrambled/coded bit source and the IFFT input buffer of the OFDM transmit chain.

Parameters:
L_AMP, 485, outer constellation magnitude (13-bit signed, 0x01E5)
S_AMP, 161, inner constellation magnitude (13-bit signed, 0x00A1)
IDX_W, 10, width of per-frame symbol index counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
bit_in  in  1  serial data bit
bit_valid  in  1  bit_in valid
bit_ready  out  1  mapper can accept a bit this cycle
bit_last  in  1  qualifies final bit of a frame
sym_real  out  13  signed I component
sym_imag  out  13  signed Q component
sym_bits  out  4  packed symbol bits carried with the point
sym_valid  out  1  output symbol valid
sym_ready  in  1  downstream accepts symbol
sym_last  out  1  symbol is last of frame
sym_index  out  IDX_W  index of presented symbol within frame, starting at 0

Behaviour:
- Bit accept: bit_valid && bit_ready.
- bit_ready = !sym_valid || sym_ready (combinational). It is deasserted only while a symbol is held and stalled.
- Collection:
  - 4-bit shift register plus 2-bit counter cnt.
  - First accepted bit of a symbol becomes sym_bits[3]; the fourth becomes sym_bits[0].
- Symbol load:
  - Triggered when the accepted bit is the 4th bit (cnt==3) or carries bit_last.
  - On the next edge, the output register loads the point and sym_valid rises. Latency is 1 cycle from the final accepted bit to sym_valid.
  - cnt returns to 0.
- Partial symbol: bit_last on bit k (k<4) pads the remaining lower positions with 0. sym_last=1 with that symbol.
- Full symbol with bit_last: sym_last=1, no padding.
- Mapping, Gray coded:
  - Real from b[3:2]: 00→-L_AMP, 01→-S_AMP, 11→+S_AMP, 10→+L_AMP.
  - Imag from b[1:0]: 00→+L_AMP, 01→+S_AMP, 11→-S_AMP, 10→-L_AMP.
  - Outputs are 13-bit two's complement.
- Output register:
  - Holds sym_real, sym_imag, sym_bits, sym_last and sym_index stable while sym_valid && !sym_ready.
  - sym_valid clears after a handshake unless a new symbol loads in the same cycle. Simultaneous drain and load gives a back-to-back symbol with no bubble.
- sym_index:
  - Increments on each symbol handshake.
  - Resets to 0 after the handshake of a sym_last symbol.
  - Wraps modulo 2^IDX_W.
- Throughput: continuous bits with sym_ready=1 gives one symbol per 4 cycles.
- Reset values:
  - sym_valid=0, sym_last=0, sym_bits=0, sym_real=0, sym_imag=0, sym_index=0.
  - Internal: cnt=0, shift register=0.
  - bit_ready=1 after reset.
- Reset mid-operation: a partial symbol is discarded and any held output symbol is dropped. The next accepted bit starts a new symbol at sym_bits[3].
- bit_valid low: no state change; cnt holds.
- bit_last with bit_valid low: ignored.

Test Plan:
- Bits 0,0,0,0, sym_ready=1 → sym_valid 1 cycle after 4th bit; sym_bits=0000, sym_real=0x1E1B (-485), sym_imag=0x01E5 (+485), sym_index=0.
- Bits 1,1,1,1 then 1,0,1,0 → symbol 0: real 0x00A1, imag 0x1F5F. Symbol 1: real 0x01E5, imag 0x1E1B, sym_index=1.
- Bits 1,1 with bit_last on the 2nd → sym_bits=1100, real 0x00A1, imag 0x01E5, sym_last=1. After the handshake, the next symbol has sym_index=0.
- Backpressure: hold sym_ready=0 with a symbol valid for 5 cycles → outputs stable and bit_ready=0 throughout. Raising sym_ready → handshake that cycle and bit_ready=1.
- Continuous stream of 32 bits, sym_ready=1 → 8 symbols, one every 4 cycles, indices 0..7, no drops or duplicates against the golden mapping table.
- Assert rst after 3 bits collected and with a stalled output symbol → next cycle sym_valid=0, sym_index=0. Next 4 bits 0,1,0,1 → sym_bits=0101, real 0x1F5F, imag 0x00A1.
